// File: rtl/invalid_id_range_sum.sv
// invalid_id_range_sum
//   Closed-form summer of "invalid IDs" in [lo,hi]: decimal numbers made of one
//   digit block repeated. mode=0 counts blocks repeated exactly twice, mode=1
//   counts any repeat count >= 2. The sum is built term by term from a
//   per-length ROM using restoring division and inclusion-exclusion.
//   A running total of all handed-off results is also kept.
// Ports
//   clock, reset_n           rising-edge clock, async active-low reset
//   in_valid/in_ready        request handshake (in_ready high only when idle)
//   lo, hi, mode             inclusive bounds and repeat mode of the request
//   out_valid/out_ready      result handshake, result held until accepted
//   sum_out, err             range sum; err flags lo>hi or hi>=10^MAX_DIGITS
//   clear_total, total_out   synchronous clear and running sum of results
module invalid_id_range_sum #(
  parameter int unsigned N_WIDTH    = 64,
  parameter int unsigned MAX_DIGITS = 18,
  parameter int unsigned SUM_WIDTH  = 128
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_WIDTH-1:0]   lo,
  input  logic [N_WIDTH-1:0]   hi,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_WIDTH-1:0] sum_out,
  output logic                 err,
  input  logic                 clear_total,
  output logic [SUM_WIDTH-1:0] total_out
);

  // ---------------------------------------------------------------------------
  // Elaboration-time term ROM
  // ---------------------------------------------------------------------------
  function automatic logic [N_WIDTH-1:0] f_pow10(input int unsigned e);
    logic [N_WIDTH-1:0] r;
    r = N_WIDTH'(1);
    for (int unsigned i = 0; i < e; i++) r = r * N_WIDTH'(10);
    return r;
  endfunction

  function automatic bit f_sqfree(input int unsigned m);
    bit ok;
    ok = 1'b1;
    for (int unsigned d = 2; d * d <= m; d++)
      if (m % (d * d) == 0) ok = 1'b0;
    return ok;
  endfunction

  // Distinct prime count of a squarefree m.
  function automatic int unsigned f_omega(input int unsigned m);
    int unsigned x;
    int unsigned n;
    x = m;
    n = 0;
    for (int unsigned d = 2; d <= m; d++)
      if (x % d == 0) begin
        n++;
        x = x / d;
      end
    return n;
  endfunction

  function automatic int unsigned f_count_terms();
    int unsigned n;
    n = 0;
    for (int unsigned len = 1; len <= MAX_DIGITS; len++)
      for (int unsigned m = 2; m <= len; m++)
        if ((len % m == 0) && f_sqfree(m)) n++;
    return n;
  endfunction

  // Length (want_fac=0) or repeat factor m (want_fac=1) of schedule entry idx.
  function automatic int unsigned f_term(input int unsigned idx, input bit want_fac);
    int unsigned n;
    int unsigned res;
    n   = 0;
    res = 0;
    for (int unsigned len = 1; len <= MAX_DIGITS; len++)
      for (int unsigned m = 2; m <= len; m++)
        if ((len % m == 0) && f_sqfree(m)) begin
          if (n == idx) res = want_fac ? m : len;
          n++;
        end
    return res;
  endfunction

  localparam int unsigned NUM_TERMS = f_count_terms();
  localparam int unsigned TW        = $clog2(NUM_TERMS + 1);
  localparam int unsigned LW        = $clog2(MAX_DIGITS + 1);
  localparam int unsigned CW        = $clog2(N_WIDTH);

  // sel 0: multiplier M, 1: smallest block 10^(p-1), 2: largest block 10^p-1
  function automatic logic [NUM_TERMS*N_WIDTH-1:0] f_rom_wide(input int unsigned sel);
    logic [NUM_TERMS*N_WIDTH-1:0] r;
    logic [N_WIDTH-1:0]           v;
    int unsigned                  len;
    int unsigned                  fac;
    int unsigned                  p;
    r = '0;
    for (int unsigned i = 0; i < NUM_TERMS; i++) begin
      len = f_term(i, 1'b0);
      fac = f_term(i, 1'b1);
      p   = len / fac;
      v   = '0;
      if (sel == 0) begin
        for (int unsigned j = 0; j < fac; j++) v = v * f_pow10(p) + N_WIDTH'(1);
      end else if (sel == 1) begin
        v = f_pow10(p - 1);
      end else begin
        v = f_pow10(p) - N_WIDTH'(1);
      end
      r[i*N_WIDTH +: N_WIDTH] = v;
    end
    return r;
  endfunction

  function automatic logic [NUM_TERMS*LW-1:0] f_rom_len();
    logic [NUM_TERMS*LW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_TERMS; i++) r[i*LW +: LW] = LW'(f_term(i, 1'b0));
    return r;
  endfunction

  // sel 0: m==2 (the only factor used in mode 0), 1: negative sign (omega even)
  function automatic logic [NUM_TERMS-1:0] f_rom_bits(input int unsigned sel);
    logic [NUM_TERMS-1:0] r;
    int unsigned          fac;
    r = '0;
    for (int unsigned i = 0; i < NUM_TERMS; i++) begin
      fac  = f_term(i, 1'b1);
      r[i] = (sel == 0) ? (fac == 2) : (f_omega(fac) % 2 == 0);
    end
    return r;
  endfunction

  function automatic logic [(MAX_DIGITS+1)*N_WIDTH-1:0] f_pow_table();
    logic [(MAX_DIGITS+1)*N_WIDTH-1:0] r;
    for (int unsigned i = 0; i <= MAX_DIGITS; i++) r[i*N_WIDTH +: N_WIDTH] = f_pow10(i);
    return r;
  endfunction

  localparam logic [NUM_TERMS*N_WIDTH-1:0]          ROM_MULT = f_rom_wide(0);
  localparam logic [NUM_TERMS*N_WIDTH-1:0]          ROM_SMIN = f_rom_wide(1);
  localparam logic [NUM_TERMS*N_WIDTH-1:0]          ROM_SMAX = f_rom_wide(2);
  localparam logic [NUM_TERMS*LW-1:0]               ROM_LEN  = f_rom_len();
  localparam logic [NUM_TERMS-1:0]                  ROM_IS2  = f_rom_bits(0);
  localparam logic [NUM_TERMS-1:0]                  ROM_NEG  = f_rom_bits(1);
  localparam logic [(MAX_DIGITS+1)*N_WIDTH-1:0]     POW10    = f_pow_table();
  localparam logic [N_WIDTH-1:0]                    POW_MAX  = f_pow10(MAX_DIGITS);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_TERM, S_DIVLO, S_DIVHI, S_CLAMP, S_MUL1, S_MUL2, S_ACC, S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [SUM_WIDTH-1:0] r_sum;
  logic                 r_err;
  logic [SUM_WIDTH-1:0] r_total;
  logic [N_WIDTH-1:0]   r_lo;
  logic [N_WIDTH-1:0]   r_hi;
  logic                 r_mode;
  logic [SUM_WIDTH-1:0] r_acc;
  logic [TW-1:0]        r_idx;
  logic [LW-1:0]        r_len_lo;
  logic [LW-1:0]        r_len_hi;
  logic [N_WIDTH-1:0]   r_m;
  logic [N_WIDTH-1:0]   r_smin;
  logic [N_WIDTH-1:0]   r_smax;
  logic                 r_neg;
  logic [N_WIDTH-1:0]   r_div_q;
  logic [N_WIDTH-1:0]   r_div_r;
  logic [CW-1:0]        r_cnt;
  logic [N_WIDTH-1:0]   r_s_lo;
  logic [N_WIDTH-1:0]   r_s_hi;
  logic [SUM_WIDTH-1:0] r_prod;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [LW-1:0]        w_cur_len;
  logic                 w_cur_is2;
  logic                 w_cur_neg;
  logic [N_WIDTH-1:0]   w_cur_m;
  logic [N_WIDTH-1:0]   w_cur_smin;
  logic [N_WIDTH-1:0]   w_cur_smax;
  logic                 w_skip;
  logic [LW-1:0]        w_len_lo;
  logic [LW-1:0]        w_len_hi;
  logic                 w_bad;
  logic [N_WIDTH:0]     w_rem_sh;
  logic                 w_ge;
  logic [N_WIDTH-1:0]   w_rem_nx;
  logic [N_WIDTH-1:0]   w_q_nx;
  logic                 w_div_last;
  logic [N_WIDTH-1:0]   w_s_lo_cl;
  logic [N_WIDTH-1:0]   w_s_hi_cl;
  logic [N_WIDTH:0]     w_pair;
  logic [N_WIDTH:0]     w_cnt;
  logic [SUM_WIDTH-1:0] w_half_prod;
  logic                 w_handoff;

  // ROM read of the entry at r_idx (zeros once the schedule is exhausted)
  always_comb begin
    w_cur_len  = '0;
    w_cur_is2  = 1'b0;
    w_cur_neg  = 1'b0;
    w_cur_m    = '0;
    w_cur_smin = '0;
    w_cur_smax = '0;
    for (int unsigned i = 0; i < NUM_TERMS; i++) begin
      if (r_idx == TW'(i)) begin
        w_cur_len  = ROM_LEN[i*LW +: LW];
        w_cur_is2  = ROM_IS2[i];
        w_cur_neg  = ROM_NEG[i];
        w_cur_m    = ROM_MULT[i*N_WIDTH +: N_WIDTH];
        w_cur_smin = ROM_SMIN[i*N_WIDTH +: N_WIDTH];
        w_cur_smax = ROM_SMAX[i*N_WIDTH +: N_WIDTH];
      end
    end
  end

  // Only lengths spanned by [lo,hi] can contribute; mode 0 keeps m=2 only
  assign w_skip = (w_cur_len < r_len_lo) || (w_cur_len > r_len_hi) || (!r_mode && !w_cur_is2);

  // Decimal length = number of powers 10^0..10^(MAX_DIGITS-1) not above x
  always_comb begin
    w_len_lo = '0;
    w_len_hi = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (r_lo >= POW10[i*N_WIDTH +: N_WIDTH]) w_len_lo = w_len_lo + LW'(1);
      if (r_hi >= POW10[i*N_WIDTH +: N_WIDTH]) w_len_hi = w_len_hi + LW'(1);
    end
  end

  assign w_bad = (r_lo > r_hi) || (r_hi >= POW_MAX);

  // One restoring-division step: shift remainder:quotient left, subtract M if it fits
  assign w_rem_sh   = {r_div_r, r_div_q[N_WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_m});
  assign w_rem_nx   = w_ge ? N_WIDTH'(w_rem_sh - {1'b0, r_m}) : N_WIDTH'(w_rem_sh);
  assign w_q_nx     = {r_div_q[N_WIDTH-2:0], w_ge};
  assign w_div_last = (r_cnt == CW'(N_WIDTH - 1));

  assign w_s_lo_cl = (r_s_lo > r_smin) ? r_s_lo : r_smin;
  assign w_s_hi_cl = (r_s_hi < r_smax) ? r_s_hi : r_smax;

  // Arithmetic series (s_lo+s_hi)*cnt/2: exactly one of the two factors is even
  assign w_pair      = {1'b0, r_s_lo} + {1'b0, r_s_hi};
  assign w_cnt       = {1'b0, r_s_hi} - {1'b0, r_s_lo} + (N_WIDTH+1)'(1);
  assign w_half_prod = w_cnt[0] ? SUM_WIDTH'(w_pair >> 1) * SUM_WIDTH'(w_cnt)
                                : SUM_WIDTH'(w_pair) * SUM_WIDTH'(w_cnt >> 1);

  assign w_handoff = r_out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Control FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_mode      <= 1'b0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_len_lo    <= '0;
      r_len_hi    <= '0;
      r_m         <= '0;
      r_smin      <= '0;
      r_smax      <= '0;
      r_neg       <= 1'b0;
      r_div_q     <= '0;
      r_div_r     <= '0;
      r_cnt       <= '0;
      r_s_lo      <= '0;
      r_s_hi      <= '0;
      r_prod      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_lo       <= lo;
            r_hi       <= hi;
            r_mode     <= mode;
            r_acc      <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_bad) begin
            r_err       <= 1'b1;
            r_sum       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_len_lo <= w_len_lo;
            r_len_hi <= w_len_hi;
            r_idx    <= '0;
            r_state  <= S_TERM;
          end
        end
        S_TERM: begin
          if (r_idx == TW'(NUM_TERMS)) begin
            r_sum       <= r_acc;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + TW'(1);
            if (!w_skip) begin
              r_m     <= w_cur_m;
              r_smin  <= w_cur_smin;
              r_smax  <= w_cur_smax;
              r_neg   <= w_cur_neg;
              r_div_q <= r_lo;
              r_div_r <= '0;
              r_cnt   <= '0;
              r_state <= S_DIVLO;
            end
          end
        end
        S_DIVLO: begin
          r_div_q <= w_q_nx;
          r_div_r <= w_rem_nx;
          r_cnt   <= r_cnt + CW'(1);
          if (w_div_last) begin
            // ceil(lo/M): round up on any remainder
            r_s_lo  <= w_q_nx + N_WIDTH'(w_rem_nx != '0);
            r_div_q <= r_hi;
            r_div_r <= '0;
            r_cnt   <= '0;
            r_state <= S_DIVHI;
          end
        end
        S_DIVHI: begin
          r_div_q <= w_q_nx;
          r_div_r <= w_rem_nx;
          r_cnt   <= r_cnt + CW'(1);
          if (w_div_last) begin
            r_s_hi  <= w_q_nx;
            r_state <= S_CLAMP;
          end
        end
        S_CLAMP: begin
          r_s_lo  <= w_s_lo_cl;
          r_s_hi  <= w_s_hi_cl;
          r_state <= (w_s_lo_cl > w_s_hi_cl) ? S_TERM : S_MUL1;
        end
        S_MUL1: begin
          r_prod  <= w_half_prod;
          r_state <= S_MUL2;
        end
        S_MUL2: begin
          r_prod  <= r_prod * SUM_WIDTH'(r_m);
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_acc   <= r_neg ? (r_acc - r_prod) : (r_acc + r_prod);
          r_state <= S_TERM;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Running total; a clear coinciding with a handoff keeps just that result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_total <= '0;
    end else if (clear_total) begin
      r_total <= w_handoff ? r_sum : '0;
    end else if (w_handoff) begin
      r_total <= r_total + r_sum;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum_out   = r_sum;
  assign err       = r_err;
  assign total_out = r_total;

endmodule
